verificador_paridade_serial: RTL
================================

Name: verificador_paridade_serial

Overview:
Serial parity checker and successor to the 5-bit combinational checker. A frame of DATA_W data bits followed by one parity bit arrives one bit per accepted cycle. The block accumulates parity across the frame, supports even or odd parity mode, and reports a registered error flag with a done pulse. It also keeps a saturating error-frame counter. It sits between a bit-serial receiver front end and status/control logic.

Parameters:
DATA_W, 5, data bits per frame (>=1); the parity bit is extra.
CNT_W, 8, width of the saturating error counter (>=1).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begins a frame when IDLE.
odd_mode  in  1  0 = even parity, 1 = odd parity; sampled only when start is accepted.
bit_in  in  1  serial bit, first bit = data MSB (b1).
bit_valid  in  1  bit_in qualifier; one bit is accepted per cycle while it is high.
abort  in  1  drops the current frame.
clr_count  in  1  synchronous clear of err_count.
busy  out  1  frame in progress (not IDLE).
done  out  1  one-cycle pulse, the result is valid.
erro  out  1  parity error of last frame; held until the next done.
dado  out  DATA_W  data word of last frame; held until the next done.
err_count  out  CNT_W  number of errored frames, saturating.

Behaviour:
- Reset (async, rst=1): the FSM goes to IDLE, and busy, done, erro, dado, err_count and all internal registers go to 0. Reset mid-frame discards the frame and no done is produced.
- States:
  - IDLE: start=1 latches odd_mode, clears the accumulator, shift register and bit index, then goes to DADOS. bit_valid is ignored in IDLE.
  - DADOS: on each bit_valid=1, shift bit_in in at the LSB (so the first bit ends at the MSB), acc ^= bit_in and increment the index. When the index reaches DATA_W it goes to PARIDADE. bit_valid=0 holds all state.
  - PARIDADE: on bit_valid=1, compute the error. Even mode: erro = acc ^ bit_in. Odd mode: erro = ~(acc ^ bit_in). On the same edge, register erro and dado, set done<=1 and go to IDLE.
- Latency: done is high for exactly the one cycle after the edge that samples the parity bit. A start in that cycle is accepted, so frames can run back to back with no gap.
- busy = (state != IDLE), registered with the state.
- start while busy is ignored; odd_mode changes mid-frame have no effect.
- abort=1 in DADOS or PARIDADE returns the FSM to IDLE on the next edge. There is no done, and erro, dado and err_count are unchanged. abort has priority over a simultaneous bit_valid. abort in IDLE has no effect, and start is ignored in a cycle where abort=1.
- err_count increments on the edge that sets done with erro=1, and stops at 2^CNT_W-1.
- If clr_count=1 in the same cycle as an increment, clear wins and the result is 0.
- done is 0 in every cycle except the one above.

Decomposition:
- Package paridade_pkg holds:
  - state encoding: IDLE=2'd0, DADOS=2'd1, PARIDADE=2'd2;
  - mode constants: PAR_PAR=1'b0, PAR_IMPAR=1'b1.
- One natural sub-module: contador_erros_sat(CNT_W) with inputs inc and clr, output count, saturating, clear priority, same clk/rst.
- The bit index width is $clog2(DATA_W+1), local to the top.

Test Plan:
1. Even mode: start, bits 1,0,1,1,0 then parity 1 -> done high 1 cycle after the parity edge; erro=0, dado=5'b10110, err_count=0. Same frame with parity 0 -> erro=1, err_count=1.
2. Odd mode: bits 0,0,0,0,0 with parity 1 -> erro=0; parity 0 -> erro=1. Exhaustive sweep of all 64 data+parity combinations in both modes, back to back, checked against an XOR model -> zero mismatches and 128 done pulses.
3. Random bit_valid gaps, plus start and odd_mode toggled while busy -> erro and dado identical to the contiguous case, and the frame count is unchanged.
4. abort after 3 data bits -> busy=0 next cycle, no done, and dado, erro and err_count keep their previous values. The next frame after start is checked correctly.
5. rst asserted mid-PARIDADE, asynchronously between edges -> all outputs 0 immediately, and there is no done after release.
6. CNT_W=2: 5 errored frames -> err_count=3, which holds. clr_count coincident with an errored done -> err_count=0.

Source files
------------

// File: rtl/paridade_pkg.sv
// Shared types and constants for the serial parity checker.
// Holds the FSM state encoding, the parity-mode constants and the error rule.
package paridade_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DADOS    = 2'd1,
    PARIDADE = 2'd2
  } estado_e;

  localparam logic PAR_PAR   = 1'b0;
  localparam logic PAR_IMPAR = 1'b1;

  // Even: acc ^ parity; odd: the complement of that.
  function automatic logic calc_erro(input logic acc, input logic bit_par, input logic modo);
    return acc ^ bit_par ^ (modo == PAR_IMPAR);
  endfunction

endpackage

// File: rtl/contador_erros_sat.sv
// Saturating error-frame counter with synchronous clear.
// Clear has priority over a coincident increment.
module contador_erros_sat #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/verificador_paridade_serial.sv
// Serial parity checker: DATA_W data bits (MSB first) then one parity bit per frame.
// Reports a registered error flag, the data word, a done pulse and a saturating error count.
module verificador_paridade_serial
  import paridade_pkg::*;
#(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              odd_mode,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              abort,
  input  logic              clr_count,
  output logic              busy,
  output logic              done,
  output logic              erro,
  output logic [DATA_W-1:0] dado,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned IdxW = $clog2(DATA_W + 1);

  estado_e           state_q, state_d;
  logic              modo_q;
  logic              acc_q;
  logic [DATA_W-1:0] shift_q;
  logic [IdxW-1:0]   idx_q;
  logic              done_q;
  logic              erro_q;
  logic [DATA_W-1:0] dado_q;

  logic aceita_start;
  logic aceita_dado;
  logic fim_quadro;
  logic erro_calc;

  // abort wins over start and bit_valid in every state
  assign aceita_start = (state_q == IDLE) && start && !abort;
  assign aceita_dado  = (state_q == DADOS) && bit_valid && !abort;
  assign fim_quadro   = (state_q == PARIDADE) && bit_valid && !abort;
  assign erro_calc    = calc_erro(acc_q, bit_in, modo_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (aceita_start) state_d = DADOS;
      end
      DADOS: begin
        if (abort) begin
          state_d = IDLE;
        end else if (aceita_dado && (idx_q == IdxW'(DATA_W - 1))) begin
          state_d = PARIDADE;
        end
      end
      PARIDADE: begin
        if (abort || bit_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modo_q  <= PAR_PAR;
      acc_q   <= 1'b0;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
      dado_q  <= '0;
    end else begin
      done_q <= fim_quadro;
      if (aceita_start) begin
        modo_q  <= odd_mode;
        acc_q   <= 1'b0;
        shift_q <= '0;
        idx_q   <= '0;
      end else if (aceita_dado) begin
        shift_q <= (shift_q << 1) | DATA_W'(bit_in);
        acc_q   <= acc_q ^ bit_in;
        idx_q   <= idx_q + IdxW'(1);
      end
      if (fim_quadro) begin
        erro_q <= erro_calc;
        dado_q <= shift_q;
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    erro = erro_q;
    dado = dado_q;
  end

  contador_erros_sat #(
    .CNT_W(CNT_W)
  ) u_contador (
    .clk  (clk),
    .rst  (rst),
    .inc  (fim_quadro && erro_calc),
    .clr  (clr_count),
    .count(err_count)
  );

endmodule
